// File: rtl/tensor_stream_unpacker_pkg.sv
// Shared tensor helpers: index widths, element counts and the streamer FSM states.
package tensor_stream_unpacker_pkg;

    // Width of an index for a dimension of size x; size-1 dims still get one bit.
    function automatic int idx_w(input int x);
        return $clog2(x < 2 ? 2 : x);
    endfunction

    // Total number of elements in a B x C x H x W tensor.
    function automatic int tensor_elems(input int b, input int c, input int h, input int w);
        return b * c * h * w;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/tensor_stream_unpacker_if.sv
// Flat-tensor capture port plus the per-element valid/ready stream with coordinates.
interface tensor_stream_unpacker_if
    import tensor_stream_unpacker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 32,
    parameter int HEIGHT     = 4,
    parameter int WIDTH      = 4
);
    localparam int N  = tensor_elems(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH);
    localparam int BW = idx_w(BATCH_SIZE);
    localparam int CW = idx_w(CHANNELS);
    localparam int HW = idx_w(HEIGHT);
    localparam int WW = idx_w(WIDTH);

    logic [N*DATA_WIDTH-1:0] tensor_in;
    logic                    tensor_valid;
    logic                    tensor_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;
    logic [BW-1:0]           m_batch;
    logic [CW-1:0]           m_chan;
    logic [HW-1:0]           m_row;
    logic [WW-1:0]           m_col;
    logic                    busy;

    // The unpacker side.
    modport master (
        input  tensor_in, tensor_valid, m_ready,
        output tensor_ready, m_data, m_valid, m_last,
               m_batch, m_chan, m_row, m_col, busy
    );

    // The producer/consumer side.
    modport slave (
        output tensor_in, tensor_valid, m_ready,
        input  tensor_ready, m_data, m_valid, m_last,
               m_batch, m_chan, m_row, m_col, busy
    );
endinterface

// File: rtl/tensor_stream_unpacker_index.sv
// Nested wrap counters walking a tensor in (b, c, h, w) order with a flat index.
module tensor_index_counter
    import tensor_stream_unpacker_pkg::*;
#(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 32,
    parameter int HEIGHT     = 4,
    parameter int WIDTH      = 4
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       clear,
    input  logic                                                       advance,
    output logic [idx_w(BATCH_SIZE)-1:0]                               batch,
    output logic [idx_w(CHANNELS)-1:0]                                 chan,
    output logic [idx_w(HEIGHT)-1:0]                                   row,
    output logic [idx_w(WIDTH)-1:0]                                    col,
    output logic [idx_w(tensor_elems(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH))-1:0] index,
    output logic                                                       is_last
);
    localparam int N  = tensor_elems(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH);
    localparam int BW = idx_w(BATCH_SIZE);
    localparam int CW = idx_w(CHANNELS);
    localparam int HW = idx_w(HEIGHT);
    localparam int WW = idx_w(WIDTH);
    localparam int IW = idx_w(N);

    logic [BW-1:0] batch_q, batch_d;
    logic [CW-1:0] chan_q,  chan_d;
    logic [HW-1:0] row_q,   row_d;
    logic [WW-1:0] col_q,   col_d;
    logic [IW-1:0] index_q, index_d;

    assign is_last = (index_q == IW'(N - 1));

    // Next coordinates: column carries into row, row into channel, channel into batch.
    always_comb begin
        batch_d = batch_q;
        chan_d  = chan_q;
        row_d   = row_q;
        col_d   = col_q;
        index_d = index_q;
        if (clear) begin
            batch_d = '0;
            chan_d  = '0;
            row_d   = '0;
            col_d   = '0;
            index_d = '0;
        end else if (advance && !is_last) begin
            index_d = index_q + IW'(1);
            if (col_q == WW'(WIDTH - 1)) begin
                col_d = '0;
                if (row_q == HW'(HEIGHT - 1)) begin
                    row_d = '0;
                    if (chan_q == CW'(CHANNELS - 1)) begin
                        chan_d  = '0;
                        batch_d = batch_q + BW'(1);
                    end else begin
                        chan_d = chan_q + CW'(1);
                    end
                end else begin
                    row_d = row_q + HW'(1);
                end
            end else begin
                col_d = col_q + WW'(1);
            end
        end
    end

    // Coordinate registers, cleared by the active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            batch_q <= '0;
            chan_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            index_q <= '0;
        end else begin
            batch_q <= batch_d;
            chan_q  <= chan_d;
            row_q   <= row_d;
            col_q   <= col_d;
            index_q <= index_d;
        end
    end

    assign batch = batch_q;
    assign chan  = chan_q;
    assign row   = row_q;
    assign col   = col_q;
    assign index = index_q;
endmodule

// File: rtl/tensor_stream_unpacker.sv
// Captures a whole flat tensor and replays it one element per valid/ready beat.
module tensor_stream_unpacker
    import tensor_stream_unpacker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 32,
    parameter int HEIGHT     = 4,
    parameter int WIDTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    tensor_stream_unpacker_if.master bus
);
    localparam int N  = tensor_elems(BATCH_SIZE, CHANNELS, HEIGHT, WIDTH);
    localparam int IW = idx_w(N);

    stream_state_e         state_q, state_d;
    logic                  capture;
    logic                  advance;
    logic                  is_last;
    logic [IW-1:0]         index;
    logic [DATA_WIDTH-1:0] shadow_q [N];

    tensor_index_counter #(
        .BATCH_SIZE (BATCH_SIZE),
        .CHANNELS   (CHANNELS),
        .HEIGHT     (HEIGHT),
        .WIDTH      (WIDTH)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (capture),
        .advance (advance),
        .batch   (bus.m_batch),
        .chan    (bus.m_chan),
        .row     (bus.m_row),
        .col     (bus.m_col),
        .index   (index),
        .is_last (is_last)
    );

    // Next state plus the capture/advance strobes for the shadow and index counter.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.tensor_valid) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (bus.m_ready) begin
                    if (is_last) state_d = ST_IDLE;
                    else         advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any stream in flight.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Shadow copy of the tensor, taken only at capture so later input changes are ignored.
    for (genvar gi = 0; gi < N; gi++) begin : g_shadow
        always_ff @(posedge clk) begin
            if (capture) shadow_q[gi] <= bus.tensor_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Every output decodes registered state only; nothing depends on m_ready combinationally.
    assign bus.tensor_ready = (state_q == ST_IDLE);
    assign bus.m_valid      = (state_q == ST_STREAM);
    assign bus.busy         = (state_q == ST_STREAM);
    assign bus.m_last       = (state_q == ST_STREAM) && is_last;
    assign bus.m_data       = (state_q == ST_STREAM) ? shadow_q[index] : '0;
endmodule

// File: tb/tb_tensor_stream_unpacker.sv
// Directed bench: 1x2x2x2 tensor (DUT A) for streaming, stalls, reset; 2x1x1x3 (DUT B) for batch wrap.
module tb_tensor_stream_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tensor_stream_unpacker_if #(.DATA_WIDTH(8), .BATCH_SIZE(1), .CHANNELS(2), .HEIGHT(2), .WIDTH(2)) ifa ();
    tensor_stream_unpacker_if #(.DATA_WIDTH(8), .BATCH_SIZE(2), .CHANNELS(1), .HEIGHT(1), .WIDTH(3)) ifb ();

    tensor_stream_unpacker #(.DATA_WIDTH(8), .BATCH_SIZE(1), .CHANNELS(2), .HEIGHT(2), .WIDTH(2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    tensor_stream_unpacker #(.DATA_WIDTH(8), .BATCH_SIZE(2), .CHANNELS(1), .HEIGHT(1), .WIDTH(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a_pattern();
        for (int i = 0; i < 8; i++) ifa.tensor_in[i*8 +: 8] = 8'(16 + i);
    endtask

    // Beat k of DUT A: element 0x10+k at (c,h,w) = (k/4, (k/2)%2, k%2).
    task automatic beat_a(input int k);
        chk($sformatf("a_valid[%0d]", k), 32'(ifa.m_valid), 32'd1);
        chk($sformatf("a_data[%0d]", k),  32'(ifa.m_data),  32'(16 + k));
        chk($sformatf("a_last[%0d]", k),  32'(ifa.m_last),  32'(k == 7));
        chk($sformatf("a_batch[%0d]", k), 32'(ifa.m_batch), 32'd0);
        chk($sformatf("a_chan[%0d]", k),  32'(ifa.m_chan),  32'(k / 4));
        chk($sformatf("a_row[%0d]", k),   32'(ifa.m_row),   32'((k / 2) % 2));
        chk($sformatf("a_col[%0d]", k),   32'(ifa.m_col),   32'(k % 2));
        chk($sformatf("a_tready[%0d]", k), 32'(ifa.tensor_ready), 32'd0);
        chk($sformatf("a_busy[%0d]", k),  32'(ifa.busy),    32'd1);
        $display("A beat %0d: data=%02h c=%0d h=%0d w=%0d last=%0d",
                 k, ifa.m_data, ifa.m_chan, ifa.m_row, ifa.m_col, ifa.m_last);
    endtask

    task automatic idle_a(input string tag);
        chk({tag, "_tready"}, 32'(ifa.tensor_ready), 32'd1);
        chk({tag, "_valid"},  32'(ifa.m_valid),      32'd0);
        chk({tag, "_busy"},   32'(ifa.busy),         32'd0);
        chk({tag, "_last"},   32'(ifa.m_last),       32'd0);
    endtask

    initial begin
        logic [3:0] rpat;
        int         exp_k;
        int         cyc;
        rpat = 4'b1001;

        ifa.tensor_valid = 1'b0; ifa.m_ready = 1'b0;
        ifb.tensor_valid = 1'b0; ifb.m_ready = 1'b0;
        load_a_pattern();
        for (int i = 0; i < 6; i++) ifb.tensor_in[i*8 +: 8] = 8'(16 + i);

        // Reset state
        step(); step();
        idle_a("rst_a");
        chk("rst_a_data", 32'(ifa.m_data), 32'd0);
        chk("rst_a_idx",  32'({ifa.m_batch, ifa.m_chan, ifa.m_row, ifa.m_col}), 32'd0);
        chk("rst_b_valid", 32'(ifb.m_valid), 32'd0);
        chk("rst_b_tready", 32'(ifb.tensor_ready), 32'd1);
        rst = 1'b1;
        step();

        // 1: full-rate stream, tensor_ready back in T+9
        ifa.tensor_valid = 1'b1;
        step();
        ifa.tensor_valid = 1'b0;
        ifa.m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            beat_a(k);
            step();
        end
        idle_a("t1_end");

        // 2+3: stall pattern 1,0,0,1 with tensor_in overwritten after capture
        ifa.tensor_valid = 1'b1;
        step();
        ifa.tensor_valid = 1'b0;
        ifa.tensor_in = '1;
        exp_k = 0;
        cyc = 0;
        while (exp_k < 8 && cyc < 40) begin
            ifa.m_ready = rpat[cyc % 4];
            beat_a(exp_k);
            step();
            if (ifa.m_ready) exp_k++;
            cyc++;
        end
        chk("t2_all_beats", 32'(exp_k), 32'd8);
        idle_a("t2_end");
        load_a_pattern();

        // 4: tensor_valid held high across two tensors
        ifa.m_ready = 1'b1;
        ifa.tensor_valid = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            beat_a(k);
            step();
        end
        idle_a("t4_gap");
        step();
        ifa.tensor_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat_a(k);
            step();
        end
        idle_a("t4_end");

        // 5: reset after the third handshake, then a fresh capture
        ifa.tensor_valid = 1'b1;
        step();
        ifa.tensor_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat_a(k);
            step();
        end
        rst = 1'b0;
        step();
        idle_a("t5_rst");
        chk("t5_data", 32'(ifa.m_data), 32'd0);
        chk("t5_idx",  32'({ifa.m_batch, ifa.m_chan, ifa.m_row, ifa.m_col}), 32'd0);
        rst = 1'b1;
        ifa.tensor_valid = 1'b1;
        step();
        ifa.tensor_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat_a(k);
            step();
        end
        idle_a("t5_end");
        ifa.m_ready = 1'b0;

        // 6: B=2, C=1, H=1, W=3 batch/column walk
        ifb.tensor_valid = 1'b1;
        step();
        ifb.tensor_valid = 1'b0;
        ifb.m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b_valid[%0d]", k), 32'(ifb.m_valid), 32'd1);
            chk($sformatf("b_data[%0d]", k),  32'(ifb.m_data),  32'(16 + k));
            chk($sformatf("b_batch[%0d]", k), 32'(ifb.m_batch), 32'(k / 3));
            chk($sformatf("b_chan[%0d]", k),  32'(ifb.m_chan),  32'd0);
            chk($sformatf("b_row[%0d]", k),   32'(ifb.m_row),   32'd0);
            chk($sformatf("b_col[%0d]", k),   32'(ifb.m_col),   32'(k % 3));
            chk($sformatf("b_last[%0d]", k),  32'(ifb.m_last),  32'(k == 5));
            $display("B beat %0d: data=%02h b=%0d w=%0d last=%0d",
                     k, ifb.m_data, ifb.m_batch, ifb.m_col, ifb.m_last);
            step();
        end
        chk("b_end_valid",  32'(ifb.m_valid),      32'd0);
        chk("b_end_tready", 32'(ifb.tensor_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
